// File: rtl/tdp_ram_pkg.sv
// Shared constants and types for the parametrised true dual-port RAM.
// Read-during-write mode encodings and the clear-sequencer state type.
package tdp_ram_pkg;

    localparam int RM_WRITE_FIRST = 0;
    localparam int RM_READ_FIRST  = 1;
    localparam int RM_NO_CHANGE   = 2;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_READY = 1'b1
    } seq_state_t;

endpackage

// File: rtl/tdp_ram_init_seq.sv
// Clear-after-reset sequencer: writes zero to one word per cycle, 0..DEPTH-1,
// then parks in READY and raises init_done.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// ST_CLEAR | zeroing word at addr each cycle; ports are locked out
// ST_READY | memory cleared, init_done=1, ports accepted
module tdp_ram_init_seq
    import tdp_ram_pkg::*;
#(
    parameter int AW = 7
) (
    input  logic          clk,
    input  logic          rst_n,
    output logic          clr_we,
    output logic [AW-1:0] clr_addr,
    output logic          init_done
);

    seq_state_t    state;
    seq_state_t    state_nxt;
    logic [AW-1:0] addr;
    logic [AW-1:0] addr_nxt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_CLEAR;
            addr  <= '0;
        end else begin
            state <= state_nxt;
            addr  <= addr_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        addr_nxt  = addr;
        clr_we    = 1'b0;
        init_done = 1'b0;
        case (state)
            ST_CLEAR: begin
                clr_we = 1'b1;
                // Terminal count is the all-ones address; wrap back to 0 on exit.
                if (addr == {AW{1'b1}}) begin
                    state_nxt = ST_READY;
                    addr_nxt  = '0;
                end else begin
                    addr_nxt = addr + AW'(1);
                end
            end
            ST_READY: begin
                init_done = 1'b1;
            end
            default: begin
                state_nxt = ST_CLEAR;
                addr_nxt  = '0;
            end
        endcase
    end

    assign clr_addr = addr;

endmodule

// File: rtl/tdp_ram_param.sv
// Parametrised true dual-port RAM with byte enables, selectable read-during-write,
// cross-port collision flag and clear-after-reset. Macro TDP_RAM_OUTREG_EN adds an output stage.
module tdp_ram_param
    import tdp_ram_pkg::*;
#(
    parameter int DW        = 8,
    parameter int AW        = 7,
    parameter int READ_MODE = 0
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            en1,
    input  logic            we1,
    input  logic [DW/8-1:0] be1,
    input  logic [AW-1:0]   a1,
    input  logic [DW-1:0]   d1,
    output logic [DW-1:0]   q1,
    input  logic            en2,
    input  logic            we2,
    input  logic [DW/8-1:0] be2,
    input  logic [AW-1:0]   a2,
    input  logic [DW-1:0]   d2,
    output logic [DW-1:0]   q2,
    output logic            coll,
    output logic            init_done
);

    localparam int NB    = DW / 8;
    localparam int DEPTH = 2 ** AW;

    logic [DW-1:0] mem [DEPTH];

    logic          clr_we;
    logic [AW-1:0] clr_addr;
    logic          ready;

    tdp_ram_init_seq #(.AW(AW)) u_init_seq (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr_we    (clr_we),
        .clr_addr  (clr_addr),
        .init_done (ready)
    );

    logic          rd1, rd2, wr1, wr2;
    logic [DW-1:0] old1, old2, new1, new2;
    logic [NB-1:0] wm1, wm2;
    logic [DW-1:0] q1_r, q2_r, q1_nxt, q2_nxt;
    logic          coll_r, coll_nxt;

    always_comb begin
        rd1  = en1 & ready;
        rd2  = en2 & ready;
        wr1  = rd1 & we1 & (|be1);
        wr2  = rd2 & we2 & (|be2);
        old1 = mem[a1];
        old2 = mem[a2];
        new1 = old1;
        new2 = old2;
        for (int i = 0; i < NB; i++) begin
            if (be1[i]) new1[8*i +: 8] = d1[8*i +: 8];
            if (be2[i]) new2[8*i +: 8] = d2[8*i +: 8];
        end
        wm1 = wr1 ? be1 : '0;
        wm2 = wr2 ? be2 : '0;
        // Same-address double write: port 1 owns every byte it enables.
        if (a1 == a2) wm2 = wm2 & ~wm1;
    end

    always_ff @(posedge clk) begin
        if (clr_we) begin
            mem[clr_addr] <= '0;
        end else begin
            for (int i = 0; i < NB; i++) begin
                if (wm1[i]) mem[a1][8*i +: 8] <= d1[8*i +: 8];
                if (wm2[i]) mem[a2][8*i +: 8] <= d2[8*i +: 8];
            end
        end
    end

    always_comb begin
        q1_nxt = q1_r;
        q2_nxt = q2_r;
        if (!ready) begin
            q1_nxt = '0;
            q2_nxt = '0;
        end else begin
            if (rd1) begin
                if (!wr1)                          q1_nxt = old1;
                else if (READ_MODE == RM_READ_FIRST) q1_nxt = old1;
                else if (READ_MODE == RM_NO_CHANGE)  q1_nxt = q1_r;
                else                               q1_nxt = new1;
            end
            if (rd2) begin
                if (!wr2)                          q2_nxt = old2;
                else if (READ_MODE == RM_READ_FIRST) q2_nxt = old2;
                else if (READ_MODE == RM_NO_CHANGE)  q2_nxt = q2_r;
                else                               q2_nxt = new2;
            end
        end
        coll_nxt = ready & en1 & en2 & (a1 == a2) & (we1 | we2);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q1_r   <= '0;
            q2_r   <= '0;
            coll_r <= 1'b0;
        end else begin
            q1_r   <= q1_nxt;
            q2_r   <= q2_nxt;
            coll_r <= coll_nxt;
        end
    end

`ifdef TDP_RAM_OUTREG_EN
    logic [DW-1:0] q1_o, q2_o;
    logic          coll_o;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q1_o   <= '0;
            q2_o   <= '0;
            coll_o <= 1'b0;
        end else if (!ready) begin
            q1_o   <= '0;
            q2_o   <= '0;
            coll_o <= 1'b0;
        end else begin
            q1_o   <= q1_r;
            q2_o   <= q2_r;
            coll_o <= coll_r;
        end
    end

    assign q1   = q1_o;
    assign q2   = q2_o;
    assign coll = coll_o;
`else
    assign q1   = q1_r;
    assign q2   = q2_r;
    assign coll = coll_r;
`endif

    assign init_done = ready;

endmodule

// File: tb/tb_tdp_ram_param.sv
// Bench for tdp_ram_param: three DW=16 instances (READ_MODE 0/1/2) share stimulus;
// a behavioural model pushes expected outputs to a queue that is popped after each edge.
module tb_tdp_ram_param;

    localparam int DW    = 16;
    localparam int AW    = 7;
    localparam int NB    = 2;
    localparam int DEPTH = 128;
`ifdef TDP_RAM_OUTREG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          en1, we1, en2, we2;
    logic [NB-1:0] be1, be2;
    logic [AW-1:0] a1, a2;
    logic [DW-1:0] d1, d2;
    logic [DW-1:0] q1_w [3];
    logic [DW-1:0] q2_w [3];
    logic          coll_w [3];
    logic          done_w [3];

    for (genvar m = 0; m < 3; m++) begin : g_dut
        tdp_ram_param #(.DW(DW), .AW(AW), .READ_MODE(m)) u_dut (
            .clk(clk), .rst_n(rst_n),
            .en1(en1), .we1(we1), .be1(be1), .a1(a1), .d1(d1), .q1(q1_w[m]),
            .en2(en2), .we2(we2), .be2(be2), .a2(a2), .d2(d2), .q2(q2_w[m]),
            .coll(coll_w[m]), .init_done(done_w[m])
        );
    end

    always #5 clk = ~clk;

    typedef struct packed {
        logic [2:0][DW-1:0] q1;
        logic [2:0][DW-1:0] q2;
        logic               coll;
    } exp_t;

    exp_t               sb[$];
    logic [DW-1:0]      mm [DEPTH];
    int                 clr_cnt;
    logic               m_init;
    logic [2:0][DW-1:0] mq1, mq2;
    logic               mcoll;
    int                 errors = 0;
    int                 checks = 0;

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp_v);
        checks++;
        assert (obs === exp_v)
        else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
        end
    endtask

    task automatic idle();
        en1 = 0; we1 = 0; be1 = '0; a1 = '0; d1 = '0;
        en2 = 0; we2 = 0; be2 = '0; a2 = '0; d2 = '0;
    endtask

    task automatic tick();
        exp_t          e, f;
        logic          init_before, rd1, rd2, wr1, wr2, p1, p2;
        logic [DW-1:0] o1, o2, n1, n2;
        init_before = m_init;
        rd1 = en1 && m_init;
        rd2 = en2 && m_init;
        wr1 = rd1 && we1 && (be1 != 0);
        wr2 = rd2 && we2 && (be2 != 0);
        o1 = mm[a1];
        o2 = mm[a2];
        n1 = o1;
        n2 = o2;
        for (int b = 0; b < NB; b++) begin
            if (be1[b]) n1[8*b +: 8] = d1[8*b +: 8];
            if (be2[b]) n2[8*b +: 8] = d2[8*b +: 8];
        end
        for (int m = 0; m < 3; m++) begin
            if (!m_init) begin
                mq1[m] = '0;
                mq2[m] = '0;
            end else begin
                if (rd1) mq1[m] = !wr1 ? o1 : (m == 0 ? n1 : (m == 1 ? o1 : mq1[m]));
                if (rd2) mq2[m] = !wr2 ? o2 : (m == 0 ? n2 : (m == 1 ? o2 : mq2[m]));
            end
        end
        mcoll = m_init && en1 && en2 && (a1 == a2) && (we1 || we2);
        e.q1 = mq1; e.q2 = mq2; e.coll = mcoll;
        sb.push_back(e);
        if (!m_init) begin
            mm[clr_cnt] = '0;
            clr_cnt++;
            m_init = (clr_cnt == DEPTH);
        end else begin
            for (int b = 0; b < NB; b++) begin
                p1 = wr1 && be1[b];
                p2 = wr2 && be2[b] && !(p1 && a1 == a2);
                if (p2) mm[a2][8*b +: 8] = d2[8*b +: 8];
                if (p1) mm[a1][8*b +: 8] = d1[8*b +: 8];
            end
        end
        @(posedge clk);
        #1;
        f = sb.pop_front();
        if (!init_before) f = '0;
        for (int m = 0; m < 3; m++) begin
            chk($sformatf("q1[m%0d]", m), q1_w[m], f.q1[m]);
            chk($sformatf("q2[m%0d]", m), q2_w[m], f.q2[m]);
            chk($sformatf("coll[m%0d]", m), DW'(coll_w[m]), DW'(f.coll));
            chk($sformatf("init_done[m%0d]", m), DW'(done_w[m]), DW'(m_init));
        end
    endtask

    task automatic settle();
        idle();
        repeat (LAT - 1) tick();
    endtask

    task automatic do_reset();
        idle();
        rst_n = 1'b0;
        #2;
        for (int m = 0; m < 3; m++) begin
            chk("rst_q1", q1_w[m], '0);
            chk("rst_q2", q2_w[m], '0);
            chk("rst_coll", DW'(coll_w[m]), '0);
            chk("rst_init_done", DW'(done_w[m]), '0);
        end
        clr_cnt = 0; m_init = 1'b0; mq1 = '0; mq2 = '0; mcoll = 1'b0;
        sb.delete();
        repeat (LAT - 1) sb.push_back('0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic run_clear_and_check_rise();
        repeat (DEPTH - 1) tick();
        chk("init_before_128", DW'(done_w[0]), '0);
        tick();
        chk("init_at_128", DW'(done_w[0]), 16'h0001);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        idle();
        do_reset();
        run_clear_and_check_rise();

        // Read back every word from both ports.
        for (int i = 0; i < DEPTH; i++) begin
            en1 = 1; a1 = AW'(i);
            en2 = 1; a2 = AW'(DEPTH - 1 - i);
            tick();
        end
        idle(); tick();

        // Port 1 write, port 2 reads next cycle.
        en1 = 1; we1 = 1; be1 = 2'b11; a1 = 7'h01; d1 = 16'h00AA; tick();
        idle(); en2 = 1; a2 = 7'h01; tick();
        settle();
        chk("rd_after_wr_q2", q2_w[0], 16'h00AA);
        chk("rd_after_wr_coll", DW'(coll_w[0]), '0);

        // Write vs read on the same edge: reader sees old word, coll pulses.
        idle(); en1 = 1; we1 = 1; be1 = 2'b11; a1 = 7'h02; d1 = 16'h0011; tick();
        en1 = 1; we1 = 1; be1 = 2'b11; a1 = 7'h02; d1 = 16'h00BB;
        en2 = 1; we2 = 0; a2 = 7'h02; tick();
        settle();
        for (int m = 0; m < 3; m++) chk("xrw_old_q2", q2_w[m], 16'h0011);
        chk("xrw_coll_hi", DW'(coll_w[1]), 16'h0001);
        idle(); tick();
        chk("xrw_coll_lo", DW'(coll_w[1]), '0);
        en2 = 1; a2 = 7'h02; tick();
        settle();
        chk("xrw_reread", q2_w[2], 16'h00BB);

        // Both ports write the same word with overlapping byte enables.
        en1 = 1; we1 = 1; be1 = 2'b01; a1 = 7'h03; d1 = 16'h1234;
        en2 = 1; we2 = 1; be2 = 2'b11; a2 = 7'h03; d2 = 16'hABCD; tick();
        settle();
        chk("ww_coll", DW'(coll_w[0]), 16'h0001);
        en1 = 1; a1 = 7'h03; tick();
        settle();
        for (int m = 0; m < 3; m++) chk("ww_merge", q1_w[m], 16'hAB34);

        // Same-port read-during-write sweep across the three instances.
        en1 = 1; we1 = 1; be1 = 2'b11; a1 = 7'h04; d1 = 16'h0055; tick();
        idle(); en1 = 1; a1 = 7'h01; tick();
        en1 = 1; we1 = 1; be1 = 2'b11; a1 = 7'h04; d1 = 16'h0066; tick();
        settle();
        chk("rdw_write_first", q1_w[0], 16'h0066);
        chk("rdw_read_first", q1_w[1], 16'h0055);
        chk("rdw_no_change", q1_w[2], 16'h00AA);

        // we with no byte enables behaves as a read; then a partial byte write.
        en1 = 1; we1 = 1; be1 = 2'b00; a1 = 7'h04; d1 = 16'h7777; tick();
        settle();
        chk("be0_is_read", q1_w[2], 16'h0066);
        en2 = 1; we2 = 1; be2 = 2'b10; a2 = 7'h04; d2 = 16'h9900; tick();
        settle();
        chk("p2_partial_wf", q2_w[0], 16'h9966);
        en1 = 1; a1 = 7'h04; en2 = 1; a2 = 7'h04; tick();
        settle();
        chk("rr_same_q1", q1_w[1], 16'h9966);
        chk("rr_same_q2", q2_w[1], 16'h9966);
        chk("rr_no_coll", DW'(coll_w[1]), '0);

        // Distinct addresses, both writing: no collision.
        en1 = 1; we1 = 1; be1 = 2'b11; a1 = 7'h05; d1 = 16'hC0DE;
        en2 = 1; we2 = 1; be2 = 2'b11; a2 = 7'h06; d2 = 16'hBEEF; tick();
        settle();
        chk("diff_addr_coll", DW'(coll_w[0]), '0);
        en1 = 1; a1 = 7'h06; en2 = 1; a2 = 7'h05; tick();
        settle();
        chk("diff_addr_q1", q1_w[0], 16'hBEEF);
        chk("diff_addr_q2", q2_w[0], 16'hC0DE);

        // Reset after writes, reset again mid-clear while ports try to write.
        idle(); tick();
        do_reset();
        for (int i = 0; i < 60; i++) begin
            en1 = 1; we1 = 1; be1 = 2'b11; a1 = AW'(i); d1 = 16'hFFFF;
            en2 = 1; we2 = 1; be2 = 2'b11; a2 = AW'(127 - i); d2 = 16'hEEEE;
            tick();
        end
        do_reset();
        run_clear_and_check_rise();
        for (int i = 0; i < DEPTH; i++) begin
            en1 = 1; a1 = AW'(i);
            en2 = 1; a2 = AW'(DEPTH - 1 - i);
            tick();
        end
        idle();
        en1 = 1; a1 = 7'h04; en2 = 1; a2 = 7'h06; tick();
        settle();
        chk("recleared_q1", q1_w[0], '0);
        chk("recleared_q2", q2_w[2], '0);
        idle(); tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
